// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, status bit positions and FSM encoding for the UART command engine.
package uart_cmd_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;

    localparam int ST_CARRY = 0;
    localparam int ST_ZERO  = 1;
    localparam int ST_TMO   = 6;
    localparam int ST_BADOP = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_OP,
        S_RX_A,
        S_RX_B,
        S_EXEC,
        S_TX_RES,
        S_TX_STAT
    } state_t;

endpackage

// File: rtl/uart_alu_cmd_alu_w.sv
// Combinational DATA_W-bit ALU; carry is the ADD carry-out or the SUB borrow.
module alu_w
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              bad_op
);

    localparam logic [DATA_W-1:0] W_MOD = DATA_W'(DATA_W);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] shamt;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b % W_MOD;

    always_comb begin
        y      = '0;
        carry  = 1'b0;
        bad_op = 1'b0;
        case (op)
            OP_ADD: begin y = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
            OP_SUB: begin y = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: y = a << shamt;
            OP_SHR: y = a >> shamt;
            OP_CMP: y = {{(DATA_W-1){1'b0}}, (a < b)};
            default: bad_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_alu_cmd.sv
// UART command engine: pops opcode/A/B frames from the RX FIFO, runs them through
// alu_w and pushes result bytes plus a status byte into the TX FIFO.
module uart_alu_cmd
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic [7:0] wr_data,
    output logic       wr_uart,
    output logic       busy,
    output logic [7:0] last_status
);

    localparam int          NB        = DATA_W / 8;
    localparam logic [3:0]  LAST_BYTE = 4'(NB - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam bit          TMO_EN    = (TIMEOUT_CYC != 0);

    state_t            state;
    logic [7:0]        opcode;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic [7:0]        status;
    logic [3:0]        byte_cnt;
    logic [31:0]       tmo_cnt;

    logic [DATA_W-1:0] alu_y;
    logic              alu_carry;
    logic              alu_bad;
    logic              bad_op;
    logic              tmo_hit;
    logic [7:0]        exec_status;

    alu_w #(.DATA_W(DATA_W)) u_alu (
        .op     (opcode[3:0]),
        .a      (a_q),
        .b      (b_q),
        .y      (alu_y),
        .carry  (alu_carry),
        .bad_op (alu_bad)
    );

    assign bad_op  = alu_bad || (opcode[7:4] != 4'd0);
    assign tmo_hit = TMO_EN && rx_empty && (tmo_cnt == TMO_LAST);

    // Handshakes are same-cycle: pop/push only while the FIFO side is ready.
    assign rd_uart = !rx_empty && (state == S_RX_OP || state == S_RX_A || state == S_RX_B);
    assign wr_uart = !tx_full && (state == S_TX_RES || state == S_TX_STAT);
    assign wr_data = (state == S_TX_STAT) ? status : res_q[DATA_W-1 -: 8];
    assign busy    = (state != S_IDLE);

    always_comb begin
        exec_status = 8'h00;
        if (bad_op) begin
            exec_status[ST_BADOP] = 1'b1;
        end else begin
            exec_status[ST_CARRY] = alu_carry;
            exec_status[ST_ZERO]  = (alu_y == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            opcode      <= 8'h00;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            status      <= 8'h00;
            byte_cnt    <= 4'd0;
            tmo_cnt     <= 32'd0;
            last_status <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    byte_cnt <= 4'd0;
                    tmo_cnt  <= 32'd0;
                    if (!rx_empty) state <= S_RX_OP;
                end
                S_RX_OP: begin
                    if (rd_uart) begin
                        opcode   <= rx_data;
                        byte_cnt <= 4'd0;
                        tmo_cnt  <= 32'd0;
                        state    <= S_RX_A;
                    end
                end
                S_RX_A: begin
                    if (rd_uart) begin
                        a_q     <= (a_q << 8) | DATA_W'(rx_data);
                        tmo_cnt <= 32'd0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= 4'd0;
                            state    <= S_RX_B;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        status <= 8'(1 << ST_TMO);
                        state  <= S_TX_STAT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_RX_B: begin
                    if (rd_uart) begin
                        b_q     <= (b_q << 8) | DATA_W'(rx_data);
                        tmo_cnt <= 32'd0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= 4'd0;
                            state    <= S_EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        status <= 8'(1 << ST_TMO);
                        state  <= S_TX_STAT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_EXEC: begin
                    res_q    <= bad_op ? '0 : alu_y;
                    status   <= exec_status;
                    byte_cnt <= 4'd0;
                    state    <= S_TX_RES;
                end
                S_TX_RES: begin
                    // Result is shifted out MSB first; tx_full simply holds everything.
                    if (wr_uart) begin
                        res_q <= res_q << 8;
                        if (byte_cnt == LAST_BYTE) state <= S_TX_STAT;
                        else byte_cnt <= byte_cnt + 4'd1;
                    end
                end
                S_TX_STAT: begin
                    if (wr_uart) begin
                        last_status <= status;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_cmd.sv
// Self-checking bench for uart_alu_cmd (DATA_W=16, TIMEOUT_CYC=100) with FIFO models.
module tb_uart_alu_cmd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic [7:0] wr_data;
    logic       wr_uart;
    logic       busy;
    logic [7:0] last_status;

    logic [7:0] rx_mem [256];
    logic [7:0] tx_mem [256];
    int rx_head = 0;
    int rx_tail = 0;
    int tx_tail = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int last_wr_cyc = 0;
    int proto_err = 0;
    int n_assert = 0;
    int n_fail = 0;

    uart_alu_cmd #(.DATA_W(16), .TIMEOUT_CYC(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rd_uart     (rd_uart),
        .tx_full     (tx_full),
        .wr_data     (wr_data),
        .wr_uart     (wr_uart),
        .busy        (busy),
        .last_status (last_status)
    );

    always #5 clk = ~clk;

    assign rx_empty = (rx_head == rx_tail);
    assign rx_data  = rx_mem[rx_head % 256];

    // FIFO side of the handshakes, sampled at the edge the DUT uses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_uart) begin
            if (rx_head == rx_tail) proto_err <= proto_err + 1;
            rx_head     <= rx_head + 1;
            last_rd_cyc <= cyc;
        end
        if (wr_uart) begin
            if (tx_full) begin
                proto_err <= proto_err + 1;
            end else begin
                tx_mem[tx_tail % 256] <= wr_data;
                tx_tail     <= tx_tail + 1;
                last_wr_cyc <= cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 16-bit unsigned operands.
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int st);
        int m;
        m = 'hFFFF;
        res = 0;
        st = 0;
        if (op > 7) begin
            res = 0;
            st = 'h80;
        end else begin
            case (op)
                0: begin res = a + b; st = (res > m) ? 1 : 0; res = res & m; end
                1: begin st = (a < b) ? 1 : 0; res = (a - b) & m; end
                2: res = a & b;
                3: res = a | b;
                4: res = a ^ b;
                5: res = (a << (b % 16)) & m;
                6: res = a >> (b % 16);
                default: res = (a < b) ? 1 : 0;
            endcase
            if (res == 0) st = st | 2;
        end
    endfunction

    task automatic send(input int b, input int maxgap);
        @(negedge clk);
        rx_mem[rx_tail % 256] = 8'(b);
        rx_tail = rx_tail + 1;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
    endtask

    task automatic send_frame(input int op, input int a, input int b, input int maxgap);
        send(op, maxgap);
        send(a >> 8, maxgap);
        send(a & 255, maxgap);
        send(b >> 8, maxgap);
        send(b & 255, maxgap);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (tx_tail < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_arrived"}, (tx_tail >= n), 1);
    endtask

    task automatic check_resp(input int base, input int op, input int a, input int b,
                              input string tag);
        int er, es, k;
        model(op, a, b, er, es);
        wait_tx(base + 3, 400, tag);
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_count"}, tx_tail - base, 3);
        check({tag, "_res_hi"}, tx_mem[base % 256], (er >> 8) & 255);
        check({tag, "_res_lo"}, tx_mem[(base + 1) % 256], er & 255);
        check({tag, "_status"}, tx_mem[(base + 2) % 256], es);
        check({tag, "_last_status"}, last_status, es);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_frame(input int op, input int a, input int b, input int maxgap,
                             input string tag);
        int base;
        base = tx_tail;
        send_frame(op, a, b, maxgap);
        check_resp(base, op, a, b, tag);
    endtask

    function automatic int pick_operand();
        case ($urandom_range(0, 3))
            0: return 0;
            1: return 'hFFFF;
            default: return int'($urandom_range(0, 'hFFFF));
        endcase
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, op, a, b, d;

        repeat (3) @(negedge clk);
        check("rst_rd_uart", rd_uart, 0);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_last_status", last_status, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame('h00, 'h1234, 'h0F0F, 0, "add_basic");
        run_frame('h00, 'hFFFF, 'h0001, 0, "add_carry");
        run_frame('h01, 'h0001, 'h0002, 0, "sub_borrow");
        run_frame('h05, 'h0001, 'h0013, 0, "shl_mod");
        run_frame('h0C, 'h1111, 'h2222, 0, "bad_low");
        run_frame('h10, 'h0001, 'h0002, 0, "bad_high");
        run_frame('h06, 'h8000, 'h000F, 1, "shr");
        run_frame('h07, 'h0003, 'h0004, 1, "cmp");

        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 11));
            if ($urandom_range(0, 7) == 0) op = op | ('h10 << $urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            run_frame(op, a, b, 3, $sformatf("rand%0d_op%0h", i, op));
        end

        // Partial frame, then silence: only a timeout status byte may come out.
        base = tx_tail;
        send('h02, 0);
        send('hAB, 0);
        wait_tx(base + 1, 400, "tmo");
        d = last_wr_cyc - last_rd_cyc;
        check("tmo_byte", tx_mem[base % 256], 8'h40);
        check("tmo_delay_in_window", (d >= 100 && d <= 102), 1);
        repeat (10) @(negedge clk);
        check("tmo_single_push", tx_tail - base, 1);
        check("tmo_busy", busy, 0);
        check("tmo_last_status", last_status, 8'h40);
        run_frame('h03, 'hA0A0, 'h0505, 0, "after_tmo");

        // Back-pressure from a full TX FIFO.
        tx_full = 1'b1;
        base = tx_tail;
        send_frame('h00, 'hFFFF, 'h0001, 0);
        repeat (40) @(negedge clk);
        check("txfull_no_push", tx_tail - base, 0);
        check("txfull_busy", busy, 1);
        tx_full = 1'b0;
        check_resp(base, 'h00, 'hFFFF, 'h0001, "txfull_release");

        // Reset in the middle of a frame.
        base = tx_tail;
        send('h00, 0);
        send('h12, 0);
        send('h34, 0);
        send('h0F, 0);
        for (int k = 0; k < 20 && rx_head != rx_tail; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rd_uart", rd_uart, 0);
        check("midrst_wr_uart", wr_uart, 0);
        check("midrst_wr_data", wr_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_last_status", last_status, 8'h00);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_push", tx_tail - base, 0);
        run_frame('h00, 'h1234, 'h0F0F, 0, "after_rst");

        check("handshake_violations", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_alu_cmd.md
# uart_alu_cmd

Parametrised UART command engine: consumes framed binary commands (opcode, operand A, operand B) from the UART core's receive FIFO, executes them on a DATA_W-bit ALU, and writes the result plus a status byte back into the transmit FIFO. It sits between `uart_top`'s FIFO ports and the board top level. It replaces button-triggered single-byte operation with an autonomous, multi-byte, width-generic protocol that has error and timeout reporting.

## Interface
- DATA_W, 16: operand/result width; a multiple of 8, from 8 to 64.
- TIMEOUT_CYC, 10_000_000: maximum idle cycles between bytes of a frame; 0 disables the timeout.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous, active-low reset.
- rx_empty  in  1  RX FIFO empty.
- rx_data  in  8  RX FIFO head byte (first-word fall-through), valid when !rx_empty.
- rd_uart  out  1  RX FIFO pop, one cycle per byte.
- tx_full  in  1  TX FIFO full.
- wr_data  out  8  byte to transmit.
- wr_uart  out  1  TX FIFO push, one cycle per byte.
- busy  out  1  high in every state except IDLE.
- last_status  out  8  status byte of the most recent response (for LEDs).

## Operation
- Frame format: opcode byte, then NB = DATA_W/8 bytes of A (MSB first), then NB bytes of B (MSB first).
- Response format: NB result bytes (MSB first), then one status byte. A timeout response is the status byte only.
- Opcodes, from opcode[3:0]:
  - 0 ADD, 1 SUB (A−B).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL (A << B mod DATA_W), 6 SHR (logical).
  - 7 CMP (result = 1 if A < B unsigned, else 0).
  - 8–15 invalid; an opcode with a nonzero upper nibble is also invalid.
- Status byte bits:
  - [0] carry: ADD carry-out or SUB borrow; 0 for all other ops.
  - [1] zero: result == 0.
  - [6] timeout.
  - [7] bad opcode.
  - All other bits 0.
- Invalid opcode: both operands are still consumed; result is 0; status = 0x80 (the zero bit is suppressed).
- FSM states: IDLE → RX_OP → RX_A → RX_B → EXEC → TX_RES → TX_STAT → IDLE.
  - IDLE moves to RX_OP when !rx_empty.
  - A byte counter (0..NB−1) sequences RX_A, RX_B and TX_RES.
  - Timeout path: RX_A/RX_B → TX_STAT, with status 0x40.
- Arithmetic is unsigned at DATA_W bits; the carry is the (DATA_W+1)th bit.

## Timing
- RX handshake: rd_uart asserts only when !rx_empty in RX_OP/RX_A/RX_B. The byte is captured on the same edge. One byte per cycle maximum.
- TX handshake: wr_uart asserts only when !tx_full in TX_RES/TX_STAT, with wr_data valid in the same cycle. While tx_full is high the FSM stalls with no data loss.
- Latency: EXEC is exactly one cycle (result and status registered). The first wr_uart can come 1 cycle after EXEC. The minimum frame-to-response-end time is 2·NB+1 RX cycles + 1 + NB+1 TX cycles.
- Timeout counter:
  - Cleared on every rd_uart and in IDLE; counts in RX_A and RX_B only.
  - When it reaches TIMEOUT_CYC−1, the partial frame is discarded and the FSM enters TX_STAT.
  - RX_OP cannot time out, since it is entered only with data present.
- last_status updates in the cycle the status byte is pushed.
- Reset values: rd_uart=0, wr_uart=0, wr_data=0x00, busy=0, last_status=0x00; FSM=IDLE; counters, operands and result are 0.
- Reset mid-frame or mid-response aborts with no further pushes. Bytes already in the FIFOs are not touched.
- If new RX bytes arrive while transmitting, they stay in the RX FIFO until IDLE.

## Structure
- Package `uart_cmd_pkg`:
  - Opcode localparams (OP_ADD..OP_CMP).
  - Status bit indices (ST_CARRY, ST_ZERO, ST_TMO, ST_BADOP).
  - FSM state encoding.
- Sub-module `alu_w`: combinational, parameter DATA_W; inputs op[3:0], a, b; outputs y, carry, bad_op.
- The FSM, byte shift registers and timeout counter live in `uart_alu_cmd`.

## Test plan
- DATA_W=16; send 00 12 34 0F 0F → TX 21 43 00; last_status=0x00.
- Send 00 FF FF 00 01 → TX 00 00 03. Send 01 00 01 00 02 → TX FF FF 01.
- Send 05 00 01 00 13 (shift by 19 mod 16 = 3) → TX 00 08 00. Send 0C 11 11 22 22 → TX 00 00 80. Send 1x-opcode 10 … → status 0x80.
- TIMEOUT_CYC=100: send 02 AB, then stall → exactly 100 idle cycles later a single push of 0x40, busy falls; a following valid frame is processed normally.
- Hold tx_full high through the response of a valid frame → no wr_uart. Release → 3 bytes pushed in order, none duplicated.
- Assert rst_n=0 for 1 cycle after the 2nd operand byte → all outputs return to reset values. The next full frame produces a correct response.
